// File: rtl/router_pkg.sv
// Shared types for the 1x3 byte packet router: header layout, FSM states,
// and the per-state busy decode used to hold the source.
package router_pkg;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    DISCARD
  } state_e;

  function automatic logic busy_of(input state_e s);
    case (s)
      WAIT_TILL_EMPTY, LOAD_FIRST_DATA, FIFO_FULL_STATE,
      LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR: busy_of = 1'b1;
      default:                                          busy_of = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Circular FIFO with idle soft reset; rdata registered one cycle after a read edge.
// Writes are dropped when full unless a read frees the slot in the same cycle.
module router_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q;
  logic [CW-1:0]    tmr_q, tmr_d;
  logic             do_rd, do_wr, flush;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd = re & ~empty;
  assign do_wr = we & (~full | do_rd);
  // Flush also swallows a write landing on the same edge.
  assign flush = ~empty & ~re & (tmr_q == CW'(TIMEOUT - 1));
  assign rdata = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = flush ? wr_ptr_d : rd_ptr_q + PW'(do_rd);
    tmr_d    = (empty | re | flush) ? '0 : tmr_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      tmr_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tmr_q    <= tmr_d;
      if (do_rd) rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/modport_router.sv
// 1x3 byte router: header address steers each packet into one of three FIFOs, parity checked.
// Bytes reach the FIFO one cycle after acceptance; busy holds the source in wait/full/parity states.
module modport_router
  import router_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb_0,
  input  logic             read_enb_1,
  input  logic             read_enb_2,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic [WIDTH-1:0] data_out_2,
  output logic             valid_out_0,
  output logic             valid_out_1,
  output logic             valid_out_2,
  output logic             busy,
  output logic             error
);

  state_e           state_q, state_d;
  hdr_t             hdr_q, hdr_in;
  logic [WIDTH-1:0] parity_q, hold_q, pbyte_q, wr_dat;
  logic             busy_q, error_q, wr_en, sel_full, sel_empty;
  logic [3:0]       full_v, empty_v;
  logic [2:0]       re_v;
  logic [WIDTH-1:0] rdata_v [3];

  assign hdr_in    = hdr_t'(data_in);
  assign re_v      = {read_enb_2, read_enb_1, read_enb_0};
  // Address 3 never has a FIFO; pad the flag vectors so the decode index stays in range.
  assign full_v[3]  = 1'b0;
  assign empty_v[3] = 1'b1;
  assign sel_full  = full_v[hdr_q.addr];
  assign sel_empty = empty_v[hdr_q.addr];

  for (genvar i = 0; i < 3; i++) begin : g_port
    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en & (hdr_q.addr == 2'(i))),
      .wdata (wr_dat),
      .re    (re_v[i]),
      .rdata (rdata_v[i]),
      .full  (full_v[i]),
      .empty (empty_v[i])
    );
  end

  assign data_out_0  = rdata_v[0];
  assign data_out_1  = rdata_v[1];
  assign data_out_2  = rdata_v[2];
  assign valid_out_0 = ~empty_v[0];
  assign valid_out_1 = ~empty_v[1];
  assign valid_out_2 = ~empty_v[2];
  assign busy        = busy_q;
  assign error       = error_q;

  always_comb begin
    wr_en  = 1'b0;
    wr_dat = data_in;
    case (state_q)
      LOAD_FIRST_DATA: begin wr_en = 1'b1; wr_dat = hdr_q; end
      LOAD_DATA:       wr_en = pkt_valid & ~sel_full;
      LOAD_AFTER_FULL: begin wr_en = 1'b1; wr_dat = hold_q; end
      LOAD_PARITY:     begin wr_en = ~sel_full; wr_dat = pbyte_q; end
      default:         ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS:
        if (pkt_valid) begin
          if (hdr_in.addr == ADDR_INVALID) state_d = DISCARD;
          else if (empty_v[hdr_in.addr])   state_d = LOAD_FIRST_DATA;
          else                             state_d = WAIT_TILL_EMPTY;
        end
      WAIT_TILL_EMPTY:    if (sel_empty) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA:
        if (pkt_valid && sel_full) state_d = FIFO_FULL_STATE;
        else if (!pkt_valid)       state_d = LOAD_PARITY;
      FIFO_FULL_STATE:    if (!sel_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    state_d = pkt_valid ? LOAD_DATA : LOAD_PARITY;
      // The parity byte waits here rather than being dropped if the FIFO is full.
      LOAD_PARITY:        if (!sel_full) state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = DECODE_ADDRESS;
      DISCARD:            if (!pkt_valid) state_d = DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= DECODE_ADDRESS;
      hdr_q    <= '0;
      parity_q <= '0;
      hold_q   <= '0;
      pbyte_q  <= '0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_of(state_d);
      case (state_q)
        DECODE_ADDRESS:  if (pkt_valid) hdr_q <= hdr_in;
        LOAD_FIRST_DATA: parity_q <= hdr_q;
        LOAD_DATA:
          if (pkt_valid) begin
            parity_q <= parity_q ^ data_in;
            if (sel_full) hold_q <= data_in;
          end else begin
            pbyte_q <= data_in;
          end
        // The source is held while here, so a low pkt_valid means data_in is the parity byte.
        LOAD_AFTER_FULL:    if (!pkt_valid) pbyte_q <= data_in;
        CHECK_PARITY_ERROR: error_q <= (pbyte_q != parity_q);
        default:            ;
      endcase
    end
  end

endmodule

// File: tb/tb_modport_router.sv
// Scoreboard bench for modport_router: packets push expected bytes per port,
// a negedge monitor pops and compares every byte the DUT delivers.
module tb_modport_router;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] rd_en;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic       busy, error;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [3][$];
  logic [2:0] pend = '0;
  logic [7:0] dout [3];
  logic [2:0] vout;
  logic [7:0] pk [$];
  logic [7:0] par;
  int         flush_cnt;

  always #5 clk = ~clk;

  modport_router #(.DEPTH(16), .WIDTH(8), .TIMEOUT(30)) dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .read_enb_0  (rd_en[0]),
    .read_enb_1  (rd_en[1]),
    .read_enb_2  (rd_en[2]),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .data_out_2  (data_out_2),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .valid_out_2 (valid_out_2),
    .busy        (busy),
    .error       (error)
  );

  assign dout[0] = data_out_0;
  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;
  assign vout    = {valid_out_2, valid_out_1, valid_out_0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // A read accepted on one edge shows up on data_out after that edge.
  initial forever begin
    @(negedge clk);
    if (reset) pend = '0;
    else begin
      for (int p = 0; p < 3; p++) begin
        if (pend[p]) begin
          if (exp_q[p].size() == 0) chk($sformatf("port%0d_extra", p), {24'd0, dout[p]}, 32'hFFFF_FFFF);
          else chk($sformatf("port%0d_data", p), {24'd0, dout[p]}, {24'd0, exp_q[p].pop_front()});
        end
        pend[p] = rd_en[p] & vout[p];
      end
    end
  end

  task automatic send_byte(input logic v, input logic [7:0] d);
    logic b;
    int   t;
    pkt_valid = v;
    data_in   = d;
    t = 0;
    do begin
      @(negedge clk);
      b = busy;
      @(posedge clk);
      #1;
      t++;
    end while (b && t < 400);
    if (b) chk("source_stall", {31'd0, b}, 32'd0);
  endtask

  task automatic send_pkt(input logic [7:0] bytes [$], input bit keep);
    if (keep) foreach (bytes[i]) exp_q[bytes[0][1:0]].push_back(bytes[i]);
    foreach (bytes[i]) send_byte(i != bytes.size() - 1, bytes[i]);
    pkt_valid = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic drain(input int p);
    int t;
    t = 0;
    rd_en[p] = 1'b1;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(exp_q[p].size() == 0 && !vout[p]) && t < 400);
    chk($sformatf("drain%0d_left", p), exp_q[p].size(), 32'd0);
    @(posedge clk);
    #1;
    rd_en[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; rd_en = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_vout", {29'd0, vout}, 32'd0);
    chk("rst_dout0", {24'd0, data_out_0}, 32'd0);
    chk("rst_dout1", {24'd0, data_out_1}, 32'd0);
    chk("rst_dout2", {24'd0, data_out_2}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Good packet to port 1; 0D^A1^B2^C3 = DD.
    pk = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    send_pkt(pk, 1'b1);
    chk("t1_other_vout", {30'd0, vout[2], vout[0]}, 32'd0);
    drain(1);
    chk("t1_error", {31'd0, error}, 32'd0);

    // Bad parity sets error, which survives a drain and a discarded packet.
    pk = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'h00};
    send_pkt(pk, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("t2_error_set", {31'd0, error}, 32'd1);
    drain(1);
    chk("t2_error_hold", {31'd0, error}, 32'd1);
    pk = '{8'h0B, 8'h77, 8'h88, 8'h00};
    send_pkt(pk, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_discard_vout", {29'd0, vout}, 32'd0);
    chk("t2_discard_error", {31'd0, error}, 32'd1);
    pk = '{8'h04, 8'h3C, 8'h38};
    send_pkt(pk, 1'b1);
    drain(0);
    chk("t2_error_clear", {31'd0, error}, 32'd0);

    // Long packet fills FIFO 0 while unread, then reads release the source.
    pk.delete();
    pk.push_back(8'hF8);
    par = 8'hF8;
    for (int i = 0; i < 62; i++) begin
      pk.push_back(8'(i * 7 + 3));
      par = par ^ 8'(i * 7 + 3);
    end
    pk.push_back(par);
    fork
      send_pkt(pk, 1'b1);
      begin : t3_reader
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!vout[0] && t < 100);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t3_busy_full", {31'd0, busy}, 32'd1);
        chk("t3_vout0_full", {31'd0, vout[0]}, 32'd1);
        @(posedge clk);
        #1 rd_en[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_busy_release", {31'd0, busy}, 32'd0);
      end
    join
    drain(0);
    chk("t3_error", {31'd0, error}, 32'd0);

    // Unread port 2 stays valid for the timeout window, then flushes.
    pk = '{8'h06, 8'h5A, 8'h5C};
    flush_cnt = 0;
    fork
      send_pkt(pk, 1'b0);
      begin : t4_count
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (vout[2]) begin flush_cnt++; seen = 1'b1; end
          else if (seen) break;
        end
      end
    join
    chk("t4_valid_cycles", flush_cnt, 32'd30);
    chk("t4_vout2_flushed", {31'd0, vout[2]}, 32'd0);

    // Second packet to a non-empty port waits until reads empty it.
    pk = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    send_pkt(pk, 1'b1);
    pk = '{8'h09, 8'h11, 8'h22, 8'h3A};
    fork
      send_pkt(pk, 1'b1);
      begin : t5_reader
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t5_wait_busy", {31'd0, busy}, 32'd1);
        drain(1);
      end
    join
    chk("t5_error", {31'd0, error}, 32'd0);

    // Reset mid-payload drops the packet; the next one still routes.
    send_byte(1'b1, 8'h0D);
    send_byte(1'b1, 8'hA1);
    send_byte(1'b1, 8'hB2);
    data_in = 8'hC3;
    chk("t6_vout1_pre", {31'd0, vout[1]}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_vout", {29'd0, vout}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_dout1", {24'd0, data_out_1}, 32'd0);
    pkt_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    pk = '{8'h06, 8'h5A, 8'h5C};
    send_pkt(pk, 1'b1);
    drain(2);
    chk("t6_error", {31'd0, error}, 32'd0);

    for (int p = 0; p < 3; p++) chk($sformatf("final_q%0d", p), exp_q[p].size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
